// File: rtl/fifo_burst_drain.sv
`default_nettype none
// ============================================================================
// Module   : fifo_burst_drain
// Purpose  : Pops entries from an almost-empty/empty-flagged FIFO and emits
//            them as valid/ready bursts of BURST_LEN beats (last_o on the
//            final beat). A burst starts only once the FIFO holds a full
//            burst. Leftover entries that sit idle for TIMEOUT cycles are
//            flushed out as single-beat bursts.
// Ports    : clk_i, rst_i (async, active-high), flush_i (sync abort)
//            fifo_empty_i / fifo_full_i / fifo_alm_empty_i / fifo_data_i
//            fifo_pop_o (combinational pop of FIFO head)
//            valid_o / ready_i / data_o / last_o (output beat register)
//            burst_cnt_o / drain_cnt_o (only with FIFO_BURST_DRAIN_STATS_EN)
// Config   : define FIFO_BURST_DRAIN_STATS_EN to add the accepted-beat
//            statistics counters.
// Revision : 1.0 - initial release
// ============================================================================
module fifo_burst_drain #(
  parameter int DATA_WIDTH = 32,
  parameter int BURST_LEN  = 4,
  parameter int TIMEOUT    = 16
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  flush_i,
  input  logic                  fifo_empty_i,
  input  logic                  fifo_full_i,
  input  logic                  fifo_alm_empty_i,
  input  logic [DATA_WIDTH-1:0] fifo_data_i,
  output logic                  fifo_pop_o,
  output logic                  valid_o,
  input  logic                  ready_i,
  output logic [DATA_WIDTH-1:0] data_o,
`ifdef FIFO_BURST_DRAIN_STATS_EN
  output logic [15:0]           burst_cnt_o,
  output logic [15:0]           drain_cnt_o,
`endif
  output logic                  last_o
);

  // Shared width for the beat and idle-timer counters.
  localparam int CLOG_BL = $clog2(BURST_LEN);
  localparam int CLOG_TO = $clog2(TIMEOUT + 1);
  localparam int CNT_W   = (CLOG_BL >= CLOG_TO) ? ((CLOG_BL > 1) ? CLOG_BL : 1)
                                                : ((CLOG_TO > 1) ? CLOG_TO : 1);
  localparam logic [CNT_W-1:0] LAST_BEAT  = CNT_W'(BURST_LEN - 1);
  localparam logic [CNT_W-1:0] TIMER_LAST = CNT_W'((TIMEOUT == 0) ? 0 : TIMEOUT - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    BURST = 2'd1,
    DRAIN = 2'd2
  } state_t;

  state_t                state_q, state_d;
  logic [CNT_W-1:0]      beat_q, beat_d;
  logic [CNT_W-1:0]      timer_q, timer_d;
  logic                  valid_q, valid_d;
  logic                  last_q, last_d;
  logic [DATA_WIDTH-1:0] data_q, data_d;

  logic trig;
  logic slot_free;
  logic pop_en;
  logic load;

  always_comb begin
    // Full covers the case where the FIFO usage count wraps to zero.
    trig      = !fifo_alm_empty_i || fifo_full_i;
    slot_free = !valid_q || ready_i;

    pop_en = 1'b0;
    case (state_q)
      BURST:   pop_en = 1'b1;
      // A DRAIN that sees a full burst available hands over to BURST
      // without popping, so the burst starts on a clean beat count.
      DRAIN:   pop_en = !trig;
      default: pop_en = 1'b0;
    endcase

    // Flush must not consume a FIFO entry it is about to discard.
    load = slot_free && pop_en && !fifo_empty_i && !flush_i;

    state_d = state_q;
    beat_d  = beat_q;
    timer_d = timer_q;
    valid_d = valid_q;
    last_d  = last_q;
    data_d  = data_q;

    if (load) begin
      data_d  = fifo_data_i;
      valid_d = 1'b1;
      last_d  = (state_q == DRAIN) || (beat_q == LAST_BEAT);
    end else if (ready_i) begin
      valid_d = 1'b0;
    end

    case (state_q)
      IDLE: begin
        if (trig) begin
          state_d = BURST;
          beat_d  = '0;
          timer_d = '0;
        end else if (fifo_empty_i) begin
          timer_d = '0;
        end else if (TIMEOUT != 0) begin
          if (timer_q == TIMER_LAST) begin
            state_d = DRAIN;
            timer_d = '0;
          end else begin
            timer_d = timer_q + CNT_W'(1);
          end
        end
      end
      BURST: begin
        // Entries were committed before entering BURST; an empty FIFO here
        // simply stalls because load stays low.
        if (load) begin
          if (beat_q == LAST_BEAT) begin
            state_d = IDLE;
            beat_d  = '0;
          end else begin
            beat_d = beat_q + CNT_W'(1);
          end
        end
      end
      DRAIN: begin
        if (trig && slot_free) begin
          state_d = BURST;
          beat_d  = '0;
        end else if (fifo_empty_i) begin
          state_d = IDLE;
          timer_d = '0;
        end
      end
      default: begin
        state_d = IDLE;
        beat_d  = '0;
        timer_d = '0;
      end
    endcase

    if (flush_i) begin
      state_d = IDLE;
      beat_d  = '0;
      timer_d = '0;
      valid_d = 1'b0;
      last_d  = 1'b0;
      data_d  = '0;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= IDLE;
      beat_q  <= '0;
      timer_q <= '0;
      valid_q <= 1'b0;
      last_q  <= 1'b0;
      data_q  <= '0;
    end else begin
      state_q <= state_d;
      beat_q  <= beat_d;
      timer_q <= timer_d;
      valid_q <= valid_d;
      last_q  <= last_d;
      data_q  <= data_d;
    end
  end

  // Pop is combinational from the load decision; held low during reset.
  assign fifo_pop_o = load && !rst_i;
  assign valid_o    = valid_q;
  assign last_o     = last_q;
  assign data_o     = data_q;

`ifdef FIFO_BURST_DRAIN_STATS_EN
  // Tags the beat in the output register with the state that loaded it.
  logic        src_burst_q, src_burst_d;
  logic [15:0] burst_cnt_q, burst_cnt_d;
  logic [15:0] drain_cnt_q, drain_cnt_d;
  logic        accept;

  always_comb begin
    accept      = valid_q && ready_i;
    src_burst_d = src_burst_q;
    burst_cnt_d = burst_cnt_q;
    drain_cnt_d = drain_cnt_q;
    if (load) begin
      src_burst_d = (state_q == BURST);
    end
    if (accept && src_burst_q && last_q) begin
      burst_cnt_d = burst_cnt_q + 16'd1;
    end
    if (accept && !src_burst_q) begin
      drain_cnt_d = drain_cnt_q + 16'd1;
    end
  end

  // Counters are intentionally insensitive to flush_i.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      src_burst_q <= 1'b0;
      burst_cnt_q <= '0;
      drain_cnt_q <= '0;
    end else begin
      src_burst_q <= src_burst_d;
      burst_cnt_q <= burst_cnt_d;
      drain_cnt_q <= drain_cnt_d;
    end
  end

  assign burst_cnt_o = burst_cnt_q;
  assign drain_cnt_o = drain_cnt_q;
`endif

endmodule
`default_nettype wire

// File: tb/tb_fifo_burst_drain.sv
`default_nettype none
// ============================================================================
// Module   : tb_fifo_burst_drain
// Purpose  : Directed self-checking bench for fifo_burst_drain with a
//            behavioural 16-deep FIFO model feeding it and a beat monitor
//            capturing accepted output beats with cycle stamps.
// Revision : 1.0 - initial release
// ============================================================================
module tb_fifo_burst_drain;

  localparam int DW    = 32;
  localparam int BL    = 4;
  localparam int TO    = 16;
  localparam int DEPTH = 16;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          flush = 1'b0;
  logic          ready = 1'b1;
  logic          push_req = 1'b0;
  logic [DW-1:0] push_data = '0;

  logic          fifo_empty, fifo_full, fifo_alm_empty, fifo_pop;
  logic [DW-1:0] fifo_data;
  logic          valid, last;
  logic [DW-1:0] data;
`ifdef FIFO_BURST_DRAIN_STATS_EN
  logic [15:0]   burst_cnt, drain_cnt;
`endif

  int tests = 0;
  int fails = 0;

  // FIFO model state
  int            cyc = 0;
  int            cnt = 0;
  int            rd_ptr = 0;
  int            wr_ptr = 0;
  logic [DW-1:0] mem [DEPTH];
  logic          pend_pop = 1'b0;
  logic          pend_push = 1'b0;
  logic [DW-1:0] pend_data = '0;

  // Monitor state
  logic [DW-1:0] cap_data [64];
  logic          cap_last [64];
  int            cap_cyc  [64];
  int            cap_n = 0;
  int            pop_cnt = 0;
  int            proto_err = 0;
  logic          prev_stall = 1'b0;
  logic [DW-1:0] prev_data = '0;
  logic          prev_last = 1'b0;

  fifo_burst_drain #(
    .DATA_WIDTH (DW),
    .BURST_LEN  (BL),
    .TIMEOUT    (TO)
  ) dut (
    .clk_i            (clk),
    .rst_i            (rst),
    .flush_i          (flush),
    .fifo_empty_i     (fifo_empty),
    .fifo_full_i      (fifo_full),
    .fifo_alm_empty_i (fifo_alm_empty),
    .fifo_data_i      (fifo_data),
    .fifo_pop_o       (fifo_pop),
    .valid_o          (valid),
    .ready_i          (ready),
    .data_o           (data),
`ifdef FIFO_BURST_DRAIN_STATS_EN
    .burst_cnt_o      (burst_cnt),
    .drain_cnt_o      (drain_cnt),
`endif
    .last_o           (last)
  );

  always #5 clk = ~clk;

  assign fifo_empty     = (cnt == 0);
  assign fifo_full      = (cnt == DEPTH);
  assign fifo_alm_empty = (cnt <= BL - 1);
  assign fifo_data      = mem[rd_ptr];

  // FIFO model: pop/push decisions are latched mid-cycle, applied at the edge.
  always @(posedge clk) begin
    if (pend_pop && cnt > 0) rd_ptr <= (rd_ptr + 1) % DEPTH;
    if (pend_push && cnt < DEPTH) begin
      mem[wr_ptr] <= pend_data;
      wr_ptr      <= (wr_ptr + 1) % DEPTH;
    end
    cnt <= cnt + ((pend_push && cnt < DEPTH) ? 1 : 0) - ((pend_pop && cnt > 0) ? 1 : 0);
    cyc <= cyc + 1;
  end

  always @(negedge clk) begin
    pend_pop  = fifo_pop;
    pend_push = push_req;
    pend_data = push_data;
    if (rst) begin
      prev_stall = 1'b0;
    end else begin
      if (prev_stall && (valid !== 1'b1 || data !== prev_data || last !== prev_last))
        proto_err++;
      if (valid && ready) begin
        if (cap_n < 64) begin
          cap_data[cap_n] = data;
          cap_last[cap_n] = last;
          cap_cyc[cap_n]  = cyc;
        end
        cap_n++;
      end
      if (fifo_pop) begin
        pop_cnt++;
        if (fifo_empty) proto_err++;
      end
      prev_stall = valid && !ready && !flush;
      prev_data  = data;
      prev_last  = last;
    end
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Fills the FIFO model while flush holds the DUT in IDLE; flush stays high.
  task automatic preload(input logic [DW-1:0] base, input int n);
    flush = 1'b1;
    for (int i = 0; i < n; i++) begin
      push_req  = 1'b1;
      push_data = base + DW'(i);
      tick(1);
    end
    push_req = 1'b0;
    tick(1);
  endtask

  task automatic test_reset;
    rst = 1'b0;
    #1 rst = 1'b1;
    #2;
    tests++; if (valid !== 1'b0) begin fails++; $display("FAIL reset_valid got %b want 0", valid); end
    tests++; if (last !== 1'b0) begin fails++; $display("FAIL reset_last got %b want 0", last); end
    tests++; if (data !== '0) begin fails++; $display("FAIL reset_data got %h want 0", data); end
    tests++; if (fifo_pop !== 1'b0) begin fails++; $display("FAIL reset_pop got %b want 0", fifo_pop); end
    tick(2);
    rst = 1'b0;
    tick(3);
    tests++; if (valid !== 1'b0) begin fails++; $display("FAIL reset_idle_valid got %b want 0", valid); end
  endtask

  task automatic test_mid_burst_reset;
    int base, pb, t;
    pb = pop_cnt;
    preload(32'hA000_0000, 8);
    flush = 1'b0;
    ready = 1'b1;
    tick(3);
    #2 rst = 1'b1;
    #1;
    tests++; if (valid !== 1'b0) begin fails++; $display("FAIL midrst_valid got %b want 0", valid); end
    tests++; if (last !== 1'b0) begin fails++; $display("FAIL midrst_last got %b want 0", last); end
    tests++; if (fifo_pop !== 1'b0) begin fails++; $display("FAIL midrst_pop got %b want 0", fifo_pop); end
    tests++; if (pop_cnt - pb !== 2) begin fails++; $display("FAIL midrst_pops_before got %0d want 2", pop_cnt - pb); end
    @(posedge clk); #1;
    rst  = 1'b0;
    base = cap_n;
    t    = cyc;
    tick(40);
    tests++; if (cap_data[base] !== 32'hA000_0002) begin fails++; $display("FAIL midrst_first_data got %h want a0000002", cap_data[base]); end
    tests++; if (cap_cyc[base] - t !== 2) begin fails++; $display("FAIL midrst_first_latency got %0d want 2", cap_cyc[base] - t); end
    tests++; if (cap_n - base !== 6) begin fails++; $display("FAIL midrst_beats got %0d want 6", cap_n - base); end
  endtask

  task automatic test_burst;
    int base, pb, t;
    int exp_st [8] = '{2, 3, 4, 5, 7, 8, 9, 10};
    base = cap_n;
    pb   = pop_cnt;
    preload(32'hA100_0000, 8);
    flush = 1'b0;
    ready = 1'b1;
    t     = cyc;
    tick(20);
    tests++; if (cap_n - base !== 8) begin fails++; $display("FAIL burst_beats got %0d want 8", cap_n - base); end
    tests++; if (pop_cnt - pb !== 8) begin fails++; $display("FAIL burst_pops got %0d want 8", pop_cnt - pb); end
    for (int i = 0; i < 8; i++) begin
      tests++;
      if (cap_data[base+i] !== 32'hA100_0000 + DW'(i) || cap_last[base+i] !== (i == 3 || i == 7)) begin
        fails++;
        $display("FAIL burst_beat%0d got %h/%b want %h/%b", i, cap_data[base+i], cap_last[base+i],
                 32'hA100_0000 + DW'(i), (i == 3 || i == 7));
      end
      tests++;
      if (cap_cyc[base+i] - t !== exp_st[i]) begin
        fails++;
        $display("FAIL burst_timing%0d got %0d want %0d", i, cap_cyc[base+i] - t, exp_st[i]);
      end
    end
  endtask

  task automatic test_ready_toggle;
    int base, pb, pe;
    base = cap_n;
    pb   = pop_cnt;
    pe   = proto_err;
    preload(32'hB000_0000, 8);
    flush = 1'b0;
    ready = 1'b1;
    for (int k = 0; k < 40; k++) begin
      tick(1);
      ready = ~ready;
    end
    ready = 1'b1;
    tick(2);
    tests++; if (cap_n - base !== 8) begin fails++; $display("FAIL toggle_beats got %0d want 8", cap_n - base); end
    tests++; if (pop_cnt - pb !== cap_n - base) begin fails++; $display("FAIL toggle_pops got %0d want %0d", pop_cnt - pb, cap_n - base); end
    tests++; if (proto_err - pe !== 0) begin fails++; $display("FAIL toggle_hold got %0d errors want 0", proto_err - pe); end
    for (int i = 0; i < 8; i++) begin
      tests++;
      if (cap_data[base+i] !== 32'hB000_0000 + DW'(i) || cap_last[base+i] !== (i == 3 || i == 7)) begin
        fails++;
        $display("FAIL toggle_beat%0d got %h/%b want %h/%b", i, cap_data[base+i], cap_last[base+i],
                 32'hB000_0000 + DW'(i), (i == 3 || i == 7));
      end
    end
  endtask

  task automatic test_timeout_drain;
    int base, pb, t, t1;
    base  = cap_n;
    pb    = pop_cnt;
    ready = 1'b1;
    t     = cyc;
    for (int i = 0; i < 3; i++) begin
      push_req  = 1'b1;
      push_data = 32'hC000_0000 + DW'(i);
      tick(1);
    end
    push_req = 1'b0;
    tick(30);
    tests++; if (cap_n - base !== 3) begin fails++; $display("FAIL drain_beats got %0d want 3", cap_n - base); end
    for (int i = 0; i < 3; i++) begin
      tests++;
      if (cap_data[base+i] !== 32'hC000_0000 + DW'(i) || cap_last[base+i] !== 1'b1 || cap_cyc[base+i] - t !== 18 + i) begin
        fails++;
        $display("FAIL drain_beat%0d got %h/%b@%0d want %h/1@%0d", i, cap_data[base+i], cap_last[base+i],
                 cap_cyc[base+i] - t, 32'hC000_0000 + DW'(i), 18 + i);
      end
    end
    // A fresh single word must wait for a whole new timeout.
    t1        = cyc;
    push_req  = 1'b1;
    push_data = 32'hC100_0000;
    tick(1);
    push_req = 1'b0;
    tick(10);
    tests++; if (pop_cnt - pb !== 3) begin fails++; $display("FAIL drain_idle_pops got %0d want 3", pop_cnt - pb); end
    tick(15);
    tests++;
    if (cap_n - base !== 4 || cap_data[base+3] !== 32'hC100_0000 || cap_last[base+3] !== 1'b1 || cap_cyc[base+3] - t1 !== 18) begin
      fails++;
      $display("FAIL drain_single got n=%0d %h/%b@%0d want n=4 c1000000/1@18", cap_n - base,
               cap_data[base+3], cap_last[base+3], cap_cyc[base+3] - t1);
    end
  endtask

  task automatic test_drain_to_burst;
    int base, pb;
    base  = cap_n;
    pb    = pop_cnt;
    ready = 1'b0;
    for (int i = 0; i < 2; i++) begin
      push_req  = 1'b1;
      push_data = 32'hD000_0000 + DW'(i);
      tick(1);
    end
    push_req = 1'b0;
    for (int k = 0; k < 40 && valid !== 1'b1; k++) tick(1);
    tests++;
    if (valid !== 1'b1 || data !== 32'hD000_0000 || last !== 1'b1) begin
      fails++;
      $display("FAIL d2b_first got v=%b %h/%b want v=1 d0000000/1", valid, data, last);
    end
    for (int i = 2; i < 6; i++) begin
      push_req  = 1'b1;
      push_data = 32'hD000_0000 + DW'(i);
      tick(1);
    end
    push_req = 1'b0;
    tick(2);
    ready = 1'b1;
    tick(40);
    tests++; if (cap_n - base !== 6) begin fails++; $display("FAIL d2b_beats got %0d want 6", cap_n - base); end
    tests++; if (pop_cnt - pb !== 6) begin fails++; $display("FAIL d2b_pops got %0d want 6", pop_cnt - pb); end
    for (int i = 0; i < 6; i++) begin
      tests++;
      if (cap_data[base+i] !== 32'hD000_0000 + DW'(i) || cap_last[base+i] !== (i == 0 || i >= 4)) begin
        fails++;
        $display("FAIL d2b_beat%0d got %h/%b want %h/%b", i, cap_data[base+i], cap_last[base+i],
                 32'hD000_0000 + DW'(i), (i == 0 || i >= 4));
      end
    end
  endtask

  task automatic test_flush;
    int base, pb;
`ifdef FIFO_BURST_DRAIN_STATS_EN
    logic [15:0] bc0, dc0;
`endif
    base = cap_n;
    pb   = pop_cnt;
    preload(32'hE000_0000, 8);
    flush = 1'b0;
    ready = 1'b0;
    tick(3);
    tests++; if (valid !== 1'b1 || data !== 32'hE000_0000) begin fails++; $display("FAIL flush_pre got v=%b %h want v=1 e0000000", valid, data); end
`ifdef FIFO_BURST_DRAIN_STATS_EN
    bc0 = burst_cnt;
    dc0 = drain_cnt;
`endif
    flush = 1'b1;
    tick(1);
    tests++; if (valid !== 1'b0 || last !== 1'b0) begin fails++; $display("FAIL flush_valid got v=%b l=%b want 0/0", valid, last); end
    tests++; if (cnt !== 7 || pop_cnt - pb !== 1) begin fails++; $display("FAIL flush_fifo got cnt=%0d pops=%0d want 7/1", cnt, pop_cnt - pb); end
`ifdef FIFO_BURST_DRAIN_STATS_EN
    tests++; if (burst_cnt !== bc0) begin fails++; $display("FAIL flush_stats got %0d want %0d", burst_cnt, bc0); end
`endif
    flush = 1'b0;
    ready = 1'b1;
    tick(40);
    tests++; if (cap_n - base !== 7) begin fails++; $display("FAIL flush_beats got %0d want 7", cap_n - base); end
    for (int i = 0; i < 7; i++) begin
      tests++;
      if (cap_data[base+i] !== 32'hE000_0001 + DW'(i) || cap_last[base+i] !== (i >= 3)) begin
        fails++;
        $display("FAIL flush_beat%0d got %h/%b want %h/%b", i, cap_data[base+i], cap_last[base+i],
                 32'hE000_0001 + DW'(i), (i >= 3));
      end
    end
`ifdef FIFO_BURST_DRAIN_STATS_EN
    tests++; if (burst_cnt - bc0 !== 16'd1 || drain_cnt - dc0 !== 16'd3) begin
      fails++;
      $display("FAIL flush_stats_end got b+%0d d+%0d want b+1 d+3", burst_cnt - bc0, drain_cnt - dc0);
    end
`endif
  endtask

  initial begin
    for (int i = 0; i < DEPTH; i++) mem[i] = '0;
    test_reset();
    test_mid_burst_reset();
    test_burst();
    test_ready_toggle();
    test_timeout_drain();
    test_drain_to_burst();
    test_flush();
    tests++; if (proto_err !== 0) begin fails++; $display("FAIL protocol got %0d errors want 0", proto_err); end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
`default_nettype wire
